// File: rtl/rv32_data_ram.sv
// Word-organised synchronous RAM responder for the RV32 data-memory port.
// Optional out-of-range fault reporting is enabled by defining RV32_DATA_RAM_FAULT_EN.
module rv32_data_ram #(
   parameter int ADDR_BITS   = 10,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read_en_in,
   input  logic        write_en_in,
   input  logic [31:0] address_in,
   input  logic [31:0] write_value_in,
   input  logic [3:0]  write_mask_in,
   output logic        ready_out,
   output logic [31:0] read_value_out,
   output logic        fault_out
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   logic [31:0] mem [0:2**ADDR_BITS-1];

   state_t                 state, next_state;
   logic [3:0]             cnt;
   logic [ADDR_BITS-1:0]   idx_q;
   logic [31:0]            wdata_q;
   logic [3:0]             mask_q;
   logic                   rd_q, wr_q, flt_q;

   logic                   accept, access;
   logic [ADDR_BITS-1:0]   acc_idx;
   logic [31:0]            acc_wdata;
   logic [3:0]             acc_mask;
   logic                   acc_rd, acc_wr, acc_flt;
   logic                   req_flt;

`ifdef RV32_DATA_RAM_FAULT_EN
   assign req_flt = |address_in[31:ADDR_BITS+2];
   logic unused_addr;
   assign unused_addr = ^address_in[1:0];
`else
   assign req_flt = 1'b0;
   logic unused_addr;
   assign unused_addr = ^{address_in[31:ADDR_BITS+2], address_in[1:0]};
`endif

   assign accept = (state == IDLE) && (read_en_in || write_en_in);

   // In IDLE the access (WAIT_STATES=0) uses the live request; otherwise the latched copy.
   always_comb begin
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_mask  = mask_q;
      acc_rd    = rd_q;
      acc_wr    = wr_q;
      acc_flt   = flt_q;
      if (state == IDLE) begin
         acc_idx   = address_in[ADDR_BITS+1:2];
         acc_wdata = write_value_in;
         acc_mask  = write_mask_in;
         acc_rd    = read_en_in;
         acc_wr    = write_en_in;
         acc_flt   = req_flt;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept) next_state = (WAIT_STATES > 0) ? WAIT : RESP;
         WAIT: if (cnt == 4'd0) next_state = RESP;
         RESP: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign access = !reset && (state != RESP) && (next_state == RESP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= next_state;
         if (accept)
            cnt <= WAIT_LOAD;
         else if (state == WAIT && cnt != 4'd0)
            cnt <= cnt - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         idx_q   <= address_in[ADDR_BITS+1:2];
         wdata_q <= write_value_in;
         mask_q  <= write_mask_in;
         rd_q    <= read_en_in;
         wr_q    <= write_en_in;
         flt_q   <= req_flt;
      end
   end

   // Read and write share the access edge; non-blocking semantics give read-before-write.
   always_ff @(posedge clk) begin
      if (reset)
         read_value_out <= 32'd0;
      else if (access && acc_flt)
         read_value_out <= 32'd0;
      else if (access && acc_rd)
         read_value_out <= mem[acc_idx];
   end

   always_ff @(posedge clk) begin
      if (access && acc_wr && !acc_flt) begin
         for (int i = 0; i < 4; i++)
            if (acc_mask[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
   end

   assign ready_out = (state == RESP);
`ifdef RV32_DATA_RAM_FAULT_EN
   assign fault_out = (state == RESP) && flt_q;
`else
   assign fault_out = 1'b0;
`endif

endmodule

// File: tb/tb_rv32_data_ram.sv
// Scoreboard bench for rv32_data_ram: a WAIT_STATES=2 instance for the main sequence
// and a WAIT_STATES=0 instance for zero-wait latency and data.
module tb_rv32_data_ram;

   localparam int WS = 2;

   typedef struct packed {
      logic [31:0] rv;
      logic        flt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd, wr;
   logic [31:0] addr, wdata;
   logic [3:0]  mask;
   logic        ready, fault;
   logic [31:0] rv;

   logic        z_rd, z_wr;
   logic [31:0] z_addr, z_wdata;
   logic [3:0]  z_mask;
   logic        z_ready, z_fault;
   logic [31:0] z_rv;

   int errors = 0;
   int checks = 0;

   exp_t        q[$];
   exp_t        zq[$];
   logic [31:0] model [0:1023];
   logic [31:0] zmodel [0:1023];
   logic [31:0] last_rv = 32'd0;
   logic [31:0] z_last_rv = 32'd0;

   always #5 clk = ~clk;

   rv32_data_ram #(.ADDR_BITS(10), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(reset), .read_en_in(rd), .write_en_in(wr),
      .address_in(addr), .write_value_in(wdata), .write_mask_in(mask),
      .ready_out(ready), .read_value_out(rv), .fault_out(fault)
   );

   rv32_data_ram #(.ADDR_BITS(10), .WAIT_STATES(0)) dut_z (
      .clk(clk), .reset(reset), .read_en_in(z_rd), .write_en_in(z_wr),
      .address_in(z_addr), .write_value_in(z_wdata), .write_mask_in(z_mask),
      .ready_out(z_ready), .read_value_out(z_rv), .fault_out(z_fault)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic exp_t predict(input logic r, input logic w, input logic [31:0] a,
                                    input logic [31:0] d, input logic [3:0] m,
                                    inout logic [31:0] mdl [0:1023], inout logic [31:0] lrv);
      exp_t e;
      logic [9:0] idx;
      logic f;
      idx = a[11:2];
`ifdef RV32_DATA_RAM_FAULT_EN
      f = (a[31:12] != 20'd0);
`else
      f = 1'b0;
`endif
      if (f) lrv = 32'd0;
      else if (r) lrv = mdl[idx];
      if (w && !f)
         for (int i = 0; i < 4; i++)
            if (m[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
      e.rv  = lrv;
      e.flt = f;
      return e;
   endfunction

   always @(negedge clk) begin
      if (ready) begin
         if (q.size() == 0) check("unexpected_ready", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            check("read_value", rv, e.rv);
            check("fault", {31'd0, fault}, {31'd0, e.flt});
         end
      end
      if (z_ready) begin
         if (zq.size() == 0) check("z_unexpected_ready", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = zq.pop_front();
            check("z_read_value", z_rv, e.rv);
            check("z_fault", {31'd0, z_fault}, {31'd0, e.flt});
         end
      end
   end

   // Called just after a negedge; returns just after a negedge.
   task automatic access(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m, input bit perturb);
      int lat;
      q.push_back(predict(r, w, a, d, m, model, last_rv));
      rd = r; wr = w; addr = a; wdata = d; mask = m;
      lat = 0;
      forever begin
         @(posedge clk);
         @(negedge clk);
         if (perturb) begin
            rd = 1'b0; wr = 1'b1; addr = 32'h30; wdata = 32'h0; mask = 4'hF;
         end
         if (ready || lat > 20) break;
         lat++;
      end
      check("latency", lat, WS);
      rd = 1'b0; wr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("ready_pulse_width", {31'd0, ready}, 32'd0);
   endtask

   task automatic access_z(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
      int lat;
      zq.push_back(predict(r, w, a, d, m, zmodel, z_last_rv));
      z_rd = r; z_wr = w; z_addr = a; z_wdata = d; z_mask = m;
      lat = 0;
      forever begin
         @(posedge clk);
         @(negedge clk);
         if (z_ready || lat > 20) break;
         lat++;
      end
      check("z_latency", lat, 0);
      z_rd = 1'b0; z_wr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("z_ready_pulse_width", {31'd0, z_ready}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0; mask = 4'd0;
      z_rd = 1'b0; z_wr = 1'b0; z_addr = 32'd0; z_wdata = 32'd0; z_mask = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready", {31'd0, ready}, 32'd0);
      check("reset_read_value", rv, 32'd0);
      check("reset_fault", {31'd0, fault}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // zero-wait instance: full write then read, partial write
      access_z(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      access_z(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      access_z(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF);
      access_z(1'b0, 1'b1, 32'h20, 32'h0000AB00, 4'b0010);
      access_z(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);

      // wait-state instance
      access(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);
      access(1'b0, 1'b1, 32'h20, 32'h0000AB00, 4'b0010, 1'b0);
      access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
      access(1'b0, 1'b1, 32'h30, 32'h00000005, 4'hF, 1'b0);
      access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
      access(1'b1, 1'b1, 32'h30, 32'h000000FF, 4'b0001, 1'b0);
      access(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
      access(1'b0, 1'b1, 32'h30, 32'h0, 4'h0, 1'b0);
      access(1'b1, 1'b0, 32'h33, 32'h0, 4'h0, 1'b0);

      // reset during the first WAIT cycle discards the pending write
      access(1'b0, 1'b1, 32'h40, 32'h11111111, 4'hF, 1'b0);
      rd = 1'b0; wr = 1'b1; addr = 32'h40; wdata = 32'hCAFEF00D; mask = 4'hF;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      wr = 1'b0;
      last_rv = 32'd0;
      check("reset_mid_ready", {31'd0, ready}, 32'd0);
      check("reset_mid_read_value", rv, 32'd0);
      repeat (4) begin
         @(negedge clk);
         check("reset_mid_no_ready", {31'd0, ready}, 32'd0);
      end
      access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);

      // upper address bits: fault or alias depending on build
      access(1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 1'b0);
      access(1'b1, 1'b1, 32'h0001_0000, 32'h12345678, 4'hF, 1'b0);
      access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", q.size() + zq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
